// File: rtl/keypad_if.sv
// Key-event handshake between the keypad scanner and its consumer.
// The scanner (master) publishes the accepted key and status flags; the
// consumer (slave) returns the acknowledge.
interface keypad_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ack
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low one-hot column drive,
// synchronizes and debounces the active-low row sense lines, and hands one
// hex key code per physical press to the consumer through a valid/ack
// handshake. No auto-repeat, no rollover: a key must be released (debounced)
// before the next one can be accepted.
module keypad_scanner #(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    keypad_if.master    kp
);
    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [3:0]       sync1_q,   sync1_d;
    logic [3:0]       rs_q,      rs_d;
    logic [DIV_W-1:0] div_q,     div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [1:0]       row_q,     row_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [3:0]       code_q,    code_d;
    logic             valid_q,   valid_d;
    logic             held_q,    held_d;
    logic             ovr_q,     ovr_d;

    logic             tick;
    logic             load;
    logic             all_high;
    logic [1:0]       win;

    // Lowest-index low row wins when several rows are pulled down.
    function automatic logic [1:0] win_row(input logic [3:0] rs);
        logic [1:0] r;
        if (!rs[0])      r = 2'd0;
        else if (!rs[1]) r = 2'd1;
        else if (!rs[2]) r = 2'd2;
        else             r = 2'd3;
        return r;
    endfunction

    // Physical keypad legend: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D,
    // with * reported as E and # as F.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = 4'hE;
            4'hD:    k = 4'h0;
            4'hE:    k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Next-state logic: tick divider, scan/debounce/held sequencing, handshake.
    always_comb begin
        sync1_d   = row_in;
        rs_d      = sync1_q;
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        all_high  = (rs_q == 4'hF);
        win       = win_row(rs_q);

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (all_high) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_d = win;
                        cnt_d = CNT_ONE;
                        if (DEBOUNCE_TICKS == 1) load = 1'b1;
                        else                     state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (all_high || win != row_q) begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (cnt_q + CNT_ONE == CNT_DONE) begin
                        load = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!all_high) begin
                        cnt_d = '0;
                    end else if (cnt_q + CNT_ONE == CNT_DONE) begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end

        if (load) begin
            state_d = ST_HELD;
            cnt_d   = '0;
        end

        col_out_d = ~(4'b0001 << col_idx_d);
        held_d    = (state_d == ST_HELD);

        // A load always wins over an ack; an unacknowledged pending key
        // being overwritten is what raises overrun.
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            code_d  = key_map(row_d, col_idx_q);
            valid_d = 1'b1;
            if (valid_q) ovr_d = !kp.key_ack;
        end else if (valid_q && kp.key_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_SCAN;
            sync1_q   <= 4'hF;
            rs_q      <= 4'hF;
            div_q     <= '0;
            col_idx_q <= 2'd0;
            col_out_q <= 4'b1110;
            row_q     <= 2'd0;
            cnt_q     <= '0;
            code_q    <= 4'h0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            rs_q      <= rs_d;
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            col_out_q <= col_out_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            ovr_q     <= ovr_d;
        end
    end

    assign col_out      = col_out_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
    assign kp.overrun   = ovr_q;
endmodule
